ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
Parametrised iterative RV32M multiply/divide unit for the EX stage of the 5-stage pipeline. It runs alongside the ALU. It accepts one operation per start handshake, computes it with a radix-2 shift-add or restoring-divide engine over XLEN cycles, and holds the result for the EX/MEM register. It supports pipeline flush and fast-path completion for RISC-V corner cases.

Parameters:
XLEN, 32, operand/result width in bits (power of two, >= 8)
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden)

Ports:
clk     in   1     clock, rising-edge
rst     in   1     asynchronous, active-low reset
start   in   1     request; sampled only in IDLE or DONE
op      in   3     funct3 of OP/MULDIV: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
a       in   XLEN  rs1 operand
b       in   XLEN  rs2 operand
flush   in   1     synchronous abort (branch mispredict / squash)
busy    out  1     high in CALC state
done    out  1     one-cycle completion pulse
result  out  XLEN  registered result; valid while done=1, held until next done

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, internal acc/quotient regs=0. Reset mid-operation aborts with no done.
- States: IDLE, CALC, DONE.
- IDLE: start=1 & flush=0 at edge E latches op, |a|, |b|, sign flags, counter=0.
  - Next state is DONE if the fast path applies, else CALC.
- Fast path (div ops only):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - DIV/REM with a=most-negative and b=-1: DIV gives a, REM gives 0.
  - Result is loaded at edge E. done=1 in cycle E+1.
- CALC: one iteration per cycle; the counter increments.
  - MUL*: a 2*XLEN product accumulator with conditional add of the multiplicand, shifting right.
  - DIV*: restoring step: shift the remainder left by 1, trial-subtract the divisor, set the quotient bit.
  - At the edge where counter==XLEN-1, the sign-corrected selection is registered into result; next state is DONE.
  - done=1 in cycle E+XLEN+1.
- Sign rules:
  - MULH: negate the product if sign(a)^sign(b).
  - MULHSU: only a is signed.
  - DIV: negate the quotient if signs differ.
  - REM: the remainder takes the sign of a.
  - MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
- DONE: done=1 for exactly this cycle, then go to IDLE.
  - start in DONE is accepted, giving back-to-back operation with the same rules as IDLE.
- start while in CALC is ignored. The pipeline holds EX stalled while busy | (start & ~done).
- flush=1 in any state: at the next edge go to IDLE; done is not asserted for the aborted op; result keeps its old value. flush has priority over start in the same cycle.
- result changes only on the edge entering DONE.

Decomposition:
- Package muldiv_types:
  - muldiv_op_t enum (funct3 encodings 3'b000..3'b111).
  - muldiv_state_t enum {IDLE, CALC, DONE}.
- Sub-module muldiv_div_step: purely combinational single restoring-division step, parametrised by XLEN.
  - Inputs: rem, dividend bit, divisor.
  - Outputs: new rem, quotient bit.
- The multiply step stays inline.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, start at cycle T -> busy T+1..T+32; done only at T+33; result=0xFFFFFFEB.
- MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE at T+33. MULH same operands -> 0x00000000. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=5, b=0 -> done at T+1, result 0xFFFFFFFF, busy never high. REM a=5, b=0 -> 5. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU a=100, b=7 -> 14. REMU same operands -> 2.
- Start DIVU, flush at T+10 -> IDLE at T+11, no done, result unchanged. Simultaneous start+flush in IDLE -> ignored. Start during CALC -> ignored, original op completes.
- Async rst low mid-CALC -> all outputs 0 immediately. Back-to-back: start MUL again in the DONE cycle -> second done at 33 cycles later with the correct result.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Opcodes match funct3 of the OP/MULDIV instruction group.
package muldiv_types;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The slave side is the unit itself; the master side is the pipeline.
interface ex_muldiv_if #(
  parameter int XLEN = 32
) ();

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );

endinterface

// File: rtl/ex_muldiv_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the caller guarantees rem_i < divisor_i.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // trial < 2*divisor, so the top bit of diff is exactly the borrow
  assign trial   = {rem_i, dvd_bit_i};
  assign diff    = trial - {1'b0, divisor_i};
  assign q_bit_o = ~diff[XLEN];
  assign rem_o   = q_bit_o ? diff[XLEN-1:0] : trial[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for EX: XLEN-cycle shift-add / restoring divide,
// single-cycle fast path for divide-by-zero and signed overflow; flush aborts silently.
module ex_muldiv
  import muldiv_types::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  muldiv_op_t        op_q, op_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_t      op_in;
  logic            a_sgn, b_sgn, b_zero, ovf, fast, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign op_in  = muldiv_op_t'(bus.op);
  assign a_sgn  = bus.a[XLEN-1] & (op_in == OP_MULH || op_in == OP_MULHSU ||
                                   op_in == OP_DIV  || op_in == OP_REM);
  assign b_sgn  = bus.b[XLEN-1] & (op_in == OP_MULH || op_in == OP_DIV || op_in == OP_REM);
  assign a_mag  = a_sgn ? -bus.a : bus.a;
  assign b_mag  = b_sgn ? -bus.b : bus.b;
  assign neg_in = (bus.op[2] & bus.op[1]) ? a_sgn : (a_sgn ^ b_sgn);

  assign b_zero = (bus.b == '0);
  assign ovf    = (op_in == OP_DIV || op_in == OP_REM) &&
                  (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
  assign fast   = bus.op[2] & (b_zero | ovf);

  // op[1] distinguishes REM* from DIV* among divide ops
  always_comb begin
    if (b_zero) fast_res = bus.op[1] ? bus.a : '1;
    else        fast_res = bus.op[1] ? '0    : bus.a;
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_neg;
  logic [XLEN-1:0]   div_rem;
  logic              div_q;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({(XLEN+1){acc_q[0]}} & {1'b0, dvs_q});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .dvd_bit_i (acc_q[XLEN-1]),
    .divisor_i (dvs_q),
    .rem_o     (div_rem),
    .q_bit_o   (div_q)
  );

  assign div_next = {div_rem, acc_q[XLEN-2:0], div_q};
  assign acc_step = op_q[2] ? div_next : mul_next;
  assign prod_neg = -acc_step;

  logic [XLEN-1:0] calc_res;

  always_comb begin
    calc_res = '0;
    case (op_q)
      OP_MUL:                        calc_res = acc_step[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = neg_q ? prod_neg[2*XLEN-1:XLEN]
                                                      : acc_step[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               calc_res = neg_q ? -acc_step[XLEN-1:0]
                                                      : acc_step[XLEN-1:0];
      OP_REM, OP_REMU:               calc_res = neg_q ? -acc_step[2*XLEN-1:XLEN]
                                                      : acc_step[2*XLEN-1:XLEN];
      default:                       calc_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (bus.start) begin
            op_d  = op_in;
            neg_d = neg_in;
            acc_d = {{XLEN{1'b0}}, a_mag};
            dvs_d = b_mag;
            cnt_d = '0;
            if (fast) begin
              result_d = fast_res;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            result_d = calc_res;
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == CALC);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed RV32M results, latency, flush and reset.
module tb_ex_muldiv;
  import muldiv_types::*;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  ex_muldiv_if #(.XLEN(32)) mif ();

  ex_muldiv #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present a request for one cycle; returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    @(posedge clk);
    #1 mif.start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done; lat=0 means timeout.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (mif.busy) bcnt++;
      if (mif.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (mif.done) cnt++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bcnt;
    start_op(op, a, b);
    wait_done(lat, bcnt);
    chk({tag, "_res"}, mif.result, exp);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, bcnt, exp_lat - 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, bcnt, cnt;
    logic [31:0] prev;
    rst       = 1'b0;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.op    = 3'b000;
    mif.a     = '0;
    mif.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", mif.busy, 0);
    chk("rst_done", mif.done, 0);
    chk("rst_result", mif.result, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_vec("mul_7_m3",     OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_vec("mulhu_ff",     OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_vec("mulh_ff",      OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_vec("mulhsu_m1_2",  OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_vec("mul_lo_2p32",  OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 33);
    run_vec("mulhu_2p32",   OP_MULHU,  32'h00010000, 32'h00010000, 32'h00000001, 33);
    run_vec("div_by0",      OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_vec("rem_by0",      OP_REM,    32'd5,        32'd0,        32'd5,        1);
    run_vec("divu_by0",     OP_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
    run_vec("remu_by0",     OP_REMU,   32'd9,        32'd0,        32'd9,        1);
    run_vec("div_ovf",      OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_vec("rem_ovf",      OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_vec("divu_min_m1",  OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_vec("div_m20_3",    OP_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, 33);
    run_vec("rem_m20_3",    OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
    run_vec("div_7_m2",     OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_vec("rem_7_m2",     OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33);
    run_vec("divu_100_7",   OP_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_vec("remu_100_7",   OP_REMU,   32'd100,      32'd7,        32'd2,        33);

    // Flush during CALC: request accepted at T, flush driven in cycle T+10
    prev = mif.result;
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 mif.flush = 1'b1;
    @(posedge clk);
    #1 mif.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", mif.busy, 0);
    chk("flush_done", mif.done, 0);
    chk("flush_result", mif.result, prev);
    count_done(40, cnt);
    chk("flush_no_done", cnt, 0);
    chk("flush_result_held", mif.result, prev);
    @(posedge clk);
    #1;

    // Start and flush together in IDLE
    mif.flush = 1'b1;
    start_op(OP_MUL, 32'd4, 32'd4);
    mif.flush = 1'b0;
    @(negedge clk);
    chk("stflush_busy", mif.busy, 0);
    count_done(40, cnt);
    chk("stflush_no_done", cnt, 0);
    @(posedge clk);
    #1;

    // A second start while busy must be ignored
    start_op(OP_MUL, 32'd7, 32'd3);
    start_op(OP_DIVU, 32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("calc_start_res", mif.result, 32'd21);
    chk("calc_start_lat", lat, 32);
    count_done(40, cnt);
    chk("calc_start_no_extra", cnt, 0);
    @(posedge clk);
    #1;

    // Back-to-back: new request presented in the DONE cycle
    start_op(OP_MUL, 32'd3, 32'd5);
    wait_done(lat, bcnt);
    chk("b2b_first_res", mif.result, 32'd15);
    chk("b2b_first_lat", lat, 33);
    start_op(OP_MUL, 32'd6, 32'd7);
    wait_done(lat, bcnt);
    chk("b2b_second_res", mif.result, 32'd42);
    chk("b2b_second_lat", lat, 33);
    chk("b2b_second_busy", bcnt, 32);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC
    start_op(OP_MUL, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", mif.busy, 0);
    chk("arst_done", mif.done, 0);
    chk("arst_result", mif.result, 0);
    #3 rst = 1'b1;
    count_done(40, cnt);
    chk("arst_no_done", cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
